// File: rtl/io_uart_pkg.sv
// io_uart_pkg -- shared definitions for the io_uart_tx transmitter.
//   Register word offsets, FSM state encoding, STATUS bit positions and the
//   FIFO depth. Build option: define IO_UART_TX_FIFO_EN for an 8-entry FIFO;
//   without it the transmit buffer is a single holding register.
package io_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_TXCOUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_CNT_LO = 3;
    localparam int STAT_OVF    = 6;

`ifdef IO_UART_TX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The STATUS count field is 3 bits wide; a full 8-entry FIFO reads as 7.
    function automatic logic [2:0] sat_count(input logic [CNT_W-1:0] cnt);
        logic [3:0] wide;
        wide = 4'(cnt);
        if (wide > 4'd7) begin
            return 3'd7;
        end else begin
            return wide[2:0];
        end
    endfunction

endpackage

// File: rtl/io_uart_fifo.sv
// io_uart_fifo -- transmit byte buffer (circular, DEPTH entries from io_uart_pkg).
//   clk, rst : clock, synchronous active-high reset (empties the buffer)
//   push/din : write din; accepted when not full, or when a pop happens too
//   pop/dout : dout is the head entry; pop removes it (ignored when empty)
//   count, full, empty : occupancy flags
module io_uart_fifo
    import io_uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty     = (count_q == CNT_W'(0));
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop && !empty;
    // A simultaneous pop frees the slot, so a full buffer still takes the push.
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        wr_ptr_d = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
        end else begin
            mem_d = mem_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx -- memory-mapped UART transmitter (8N1, LSB first).
//   clk, rst      : clock, synchronous active-high reset
//   en            : bank select; no register effect and rdata=0 when low
//   memWrite[3:0] : byte-lane write enables
//   addr[10:0]    : word address, only addr[1:0] decoded
//   wdata/rdata   : write data / combinational read data
//   tx            : serial line, idle high
//   irq           : high while the buffer is empty and the line is idle
// Registers: 0 TXDATA(W) 1 STATUS(R/W1C) 2 DIVISOR(R/W) 3 TXCOUNT(R, write clears).
// Build option: IO_UART_TX_FIFO_EN selects the 8-deep FIFO (see io_uart_pkg).
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter logic [15:0] RESET_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  memWrite,
    input  logic [10:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    uart_state_e      state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [15:0]      bit_div_q, bit_div_d;
    logic [15:0]      divisor_q, divisor_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      txcount_q, txcount_d;

    logic             wr_txdata_s, ovf_clr_s, cnt_clr_s, bit_end_s;
    logic             pop_s, drop_s, stop_done_s;
    logic [7:0]       fifo_dout_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s, fifo_empty_s;
    logic             unused_s;

    assign unused_s    = ^{addr[10:2], wdata[31:16]};
    assign wr_txdata_s = en && memWrite[0] && (addr[1:0] == REG_TXDATA);
    assign ovf_clr_s   = en && memWrite[0] && wdata[STAT_OVF] && (addr[1:0] == REG_STATUS);
    assign cnt_clr_s   = en && (|memWrite) && (addr[1:0] == REG_TXCOUNT);
    // bit_div_q is the period latched at the last bit boundary, so a DIVISOR
    // write never stretches or cuts the bit already in flight.
    assign bit_end_s   = (timer_q == bit_div_q);
    assign pop_s       = !fifo_empty_s &&
                         ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end_s));
    assign drop_s      = wr_txdata_s && fifo_full_s && !pop_s;

    io_uart_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata_s),
        .pop   (pop_s),
        .din   (wdata[7:0]),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame sequencer: START, 8 data bits LSB first, STOP, back-to-back frames.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_div_d   = bit_div_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        stop_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d   = 16'd0;
                bit_idx_d = 3'd0;
                tx_d      = 1'b1;
                if (!fifo_empty_s) begin
                    shift_d   = fifo_dout_s;
                    bit_div_d = divisor_q;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    timer_d   = 16'd0;
                    bit_div_d = divisor_q;
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d   = timer_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    timer_d   = 16'd0;
                    bit_div_d = divisor_q;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d   = timer_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    timer_d     = 16'd0;
                    bit_div_d   = divisor_q;
                    stop_done_s = 1'b1;
                    if (!fifo_empty_s) begin
                        shift_d = fifo_dout_s;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = 16'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Register-file updates: DIVISOR lanes, sticky overflow, frame counter.
    always_comb begin
        divisor_d = divisor_q;
        if (en && (addr[1:0] == REG_DIVISOR)) begin
            if (memWrite[0]) begin
                divisor_d[7:0] = wdata[7:0];
            end else begin
                divisor_d[7:0] = divisor_q[7:0];
            end
            if (memWrite[1]) begin
                divisor_d[15:8] = wdata[15:8];
            end else begin
                divisor_d[15:8] = divisor_q[15:8];
            end
        end else begin
            divisor_d = divisor_q;
        end
        // A dropped byte outranks a same-cycle clear.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (cnt_clr_s) begin
            txcount_d = 32'd0;
        end else if (stop_done_s) begin
            txcount_d = txcount_q + 32'd1;
        end else begin
            txcount_d = txcount_q;
        end
    end

    // All state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= 16'd0;
            bit_div_q  <= RESET_DIV;
            divisor_q  <= RESET_DIV;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            txcount_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_div_q  <= bit_div_d;
            divisor_q  <= divisor_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            txcount_q  <= txcount_d;
        end
    end

    // Same-cycle read mux for the single-cycle CPU.
    always_comb begin
        rdata = 32'd0;
        if (en) begin
            case (addr[1:0])
                REG_STATUS: begin
                    rdata[STAT_OVF]         = overflow_q;
                    rdata[STAT_CNT_LO +: 3] = sat_count(fifo_count_s);
                    rdata[STAT_EMPTY]       = fifo_empty_s;
                    rdata[STAT_FULL]        = fifo_full_s;
                    rdata[STAT_BUSY]        = (state_q != ST_IDLE);
                end
                REG_DIVISOR: rdata = {16'd0, divisor_q};
                REG_TXCOUNT: rdata = txcount_q;
                default:     rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

    assign tx  = tx_q;
    // Decoded from registered state only, so it is glitch-free.
    assign irq = fifo_empty_s && (state_q == ST_IDLE);

endmodule

// File: tb/tb_io_uart_tx.sv
module tb_io_uart_tx;

    logic        clk, rst, en;
    logic [3:0]  memWrite;
    logic [10:0] addr;
    logic [31:0] wdata, rdata;
    logic        tx, irq;

`ifdef IO_UART_TX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    io_uart_tx #(.RESET_DIV(16'd433)) dut (
        .clk(clk), .rst(rst), .en(en), .memWrite(memWrite), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Frame schedule model: byte j pushed at edge fp, popped at edge fs,
    // line busy with its frame from edge fs up to edge fe.
    int         fp [1024];
    int         fs [1024];
    int         fe [1024];
    logic [7:0] fd [1024];
    int         nfr, last_e, dper;
    logic       ovf_m;

    typedef struct {
        logic        wr;
        logic        en;
        logic [3:0]  be;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_bus();
        en = 1'b0; memWrite = 4'd0; addr = 11'd0; wdata = 32'd0;
    endtask

    task automatic bus(input logic e, input logic [3:0] be, input logic [10:0] a, input logic [31:0] d);
        en = e; memWrite = be; addr = a; wdata = d;
        step();
        idle_bus();
    endtask

    task automatic rd(input logic [10:0] a, output logic [31:0] d);
        en = 1'b1; memWrite = 4'd0; addr = a;
        #1;
        d = rdata;
        en = 1'b0; addr = 11'd0;
    endtask

    task automatic setv(input int i, input logic w, input logic e, input logic [3:0] be,
                        input logic [10:0] a, input logic [31:0] d, input logic [31:0] x);
        vecs[i].wr = w; vecs[i].en = e; vecs[i].be = be;
        vecs[i].addr = a; vecs[i].wdata = d; vecs[i].exp = x;
    endtask

    function automatic logic m_tx(input int t);
        for (int j = 0; j < nfr; j++) begin
            if (t >= fs[j] && t < fe[j]) begin
                int k;
                k = (t - fs[j]) / dper;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return fd[j][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic m_irq(input int t);
        for (int j = 0; j < nfr; j++) begin
            if (t >= fp[j] && t < fe[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_push(input int t, input logic [7:0] b);
        int occ, popt, s;
        occ = 0; popt = 0;
        for (int j = 0; j < nfr; j++) begin
            if (fp[j] < t && t <= fs[j]) occ++;
            if (fs[j] == t) popt = 1;
        end
        if (occ - popt < DEPTH) begin
            s = (t + 1 > last_e) ? t + 1 : last_e;
            fp[nfr] = t; fs[nfr] = s; fe[nfr] = s + 10 * dper; fd[nfr] = b;
            last_e = s + 10 * dper;
            nfr++;
        end else begin
            ovf_m = 1'b1;
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        logic [9:0]  frame;
        logic [7:0]  b;
        int          i, w, pct, dv, len;

        idle_bus();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq", 32'(irq), 32'd1);

        // Register map vectors.
        setv(0,  1'b0, 1'b1, 4'h0, 11'd1,     32'h0,        32'h04);
        setv(1,  1'b0, 1'b1, 4'h0, 11'd2,     32'h0,        32'h1B1);
        setv(2,  1'b0, 1'b1, 4'h0, 11'd3,     32'h0,        32'h0);
        setv(3,  1'b0, 1'b1, 4'h0, 11'd0,     32'h0,        32'h0);
        setv(4,  1'b0, 1'b0, 4'h0, 11'd2,     32'h0,        32'h0);
        setv(5,  1'b1, 1'b0, 4'h3, 11'd2,     32'h5,        32'h1B1);
        setv(6,  1'b1, 1'b1, 4'h1, 11'd2,     32'h1234,     32'h134);
        setv(7,  1'b1, 1'b1, 4'h2, 11'd2,     32'h5600,     32'h5634);
        setv(8,  1'b1, 1'b1, 4'hC, 11'd2,     32'hFFFF0000, 32'h5634);
        setv(9,  1'b0, 1'b1, 4'h0, 11'h7FE,   32'h0,        32'h5634);
        setv(10, 1'b1, 1'b1, 4'h2, 11'd0,     32'hAA,       32'h0);
        setv(11, 1'b0, 1'b1, 4'h0, 11'd1,     32'h0,        32'h04);
        setv(12, 1'b1, 1'b1, 4'hF, 11'd2,     32'hABCD0003, 32'h3);
        setv(13, 1'b0, 1'b1, 4'h0, 11'h405,   32'h0,        32'h04);
        setv(14, 1'b1, 1'b1, 4'h8, 11'd3,     32'h0,        32'h0);
        setv(15, 1'b0, 1'b0, 4'h0, 11'd3,     32'h0,        32'h0);
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].wr) begin
                bus(vecs[v].en, vecs[v].be, vecs[v].addr, vecs[v].wdata);
                rd(vecs[v].addr, rv);
            end else begin
                en = vecs[v].en; memWrite = 4'd0; addr = vecs[v].addr;
                #1;
                rv = rdata;
                idle_bus();
            end
            chk($sformatf("vec%0d", v), rv, vecs[v].exp);
        end

        // 0xA5 at DIVISOR=3: start, 1,0,1,0,0,1,0,1, stop, 4 clk each.
        bus(1'b1, 4'h1, 11'd0, 32'hA5);
        chk("a5_latency_tx", 32'(tx), 32'd1);
        chk("a5_irq_low", 32'(irq), 32'd0);
        step();
        frame = {1'b1, 8'hA5, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("a5_bit%0d_c%0d", bi, c), 32'(tx), 32'(frame[bi]));
                if (bi == 2 && c == 0) begin
                    rd(11'd1, rv);
                    chk("a5_status_busy", rv, 32'h05);
                end
                step();
            end
        end
        chk("a5_end_tx", 32'(tx), 32'd1);
        chk("a5_end_irq", 32'(irq), 32'd1);
        rd(11'd3, rv);
        chk("a5_txcount", rv, 32'd1);

        // DIVISOR change mid start bit; en=0 accesses ignored.
        bus(1'b1, 4'h1, 11'd0, 32'h55);
        step();
        frame = {1'b1, 8'h55, 1'b0};
        i = 0;
        for (int bi = 0; bi < 10; bi++) begin
            len = (bi == 0) ? 4 : 8;
            for (int c = 0; c < len; c++) begin
                chk($sformatf("div_bit%0d_c%0d", bi, c), 32'(tx), 32'(frame[bi]));
                if (i == 1) begin
                    bus(1'b1, 4'h3, 11'd2, 32'd7);
                end else if (i == 3) begin
                    en = 1'b0; memWrite = 4'h3; addr = 11'd2; wdata = 32'd1;
                    #1;
                    chk("en0_rdata", rdata, 32'd0);
                    step();
                    idle_bus();
                end else if (i == 4) begin
                    bus(1'b0, 4'h1, 11'd0, 32'h77);
                end else begin
                    step();
                end
                i++;
            end
        end
        chk("div_end_tx", 32'(tx), 32'd1);
        chk("div_end_irq", 32'(irq), 32'd1);
        rd(11'd3, rv);
        chk("div_txcount", rv, 32'd2);
        rd(11'd2, rv);
        chk("div_value", rv, 32'd7);

        // Reset in the middle of data bit 3 with a byte still queued.
        bus(1'b1, 4'h3, 11'd2, 32'd3);
        bus(1'b1, 4'h1, 11'd0, 32'hA5);
        bus(1'b1, 4'h1, 11'd0, 32'h3C);
        chk("rst_start_tx", 32'(tx), 32'd0);
        for (int c = 0; c < 17; c++) step();
        chk("rst_in_bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd1);
        rd(11'd1, rv);
        chk("rst_status", rv, 32'h04);
        rd(11'd3, rv);
        chk("rst_txcount", rv, 32'd0);
        rd(11'd2, rv);
        chk("rst_divisor", rv, 32'd433);
        for (int c = 0; c < 20; c++) step();
        chk("rst_discard_tx", 32'(tx), 32'd1);
        rd(11'd3, rv);
        chk("rst_discard_cnt", rv, 32'd0);

        // Overflow behaviour.
`ifdef IO_UART_TX_FIFO_EN
        bus(1'b1, 4'h3, 11'd2, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 9) begin
                rd(11'd1, rv);
                chk("fifo_full_status", rv, 32'h3B);
            end
            bus(1'b1, 4'h1, 11'd0, 32'(k + 1));
        end
        rd(11'd1, rv);
        chk("fifo_ovf_status", rv, 32'h7B);
`else
        bus(1'b1, 4'h3, 11'd2, 32'd3);
        bus(1'b1, 4'h1, 11'd0, 32'h11);
        rd(11'd1, rv);
        chk("hold_1st_status", rv, 32'h0A);
        bus(1'b1, 4'h1, 11'd0, 32'h22);
        rd(11'd1, rv);
        chk("hold_2nd_status", rv, 32'h0B);
        bus(1'b1, 4'h1, 11'd0, 32'h33);
        rd(11'd1, rv);
        chk("hold_ovf_status", rv, 32'h4B);
`endif
        bus(1'b1, 4'h2, 11'd1, 32'h40);
        rd(11'd1, rv);
        chk("w1c_lane1_keeps", rv & 32'h40, 32'h40);
        bus(1'b1, 4'h1, 11'd1, 32'h40);
        rd(11'd1, rv);
        chk("w1c_clears", rv & 32'h40, 32'h0);
        w = 0;
        while (irq !== 1'b1 && w < 3000) begin
            step();
            w++;
        end
        chk("ovf_drain_timeout", 32'(w < 3000), 32'd1);
        rd(11'd3, rv);
        chk("ovf_txcount", rv, (DEPTH == 8) ? 32'd9 : 32'd2);

        // Randomized traffic against the frame schedule model.
        for (int ph = 0; ph < 3; ph++) begin
            dv  = (ph == 2) ? 3 : ph;
            pct = $urandom_range(8, 30);
            rst = 1'b1;
            step();
            rst = 1'b0;
            nfr = 0; last_e = 0; ovf_m = 1'b0; dper = dv + 1;
            bus(1'b1, 4'h3, 11'd2, 32'(dv));
            for (int c = 0; c < 700; c++) begin
                chk($sformatf("rnd_tx d%0d t%0d", dv, cyc), 32'(tx), 32'(m_tx(cyc)));
                chk($sformatf("rnd_irq d%0d t%0d", dv, cyc), 32'(irq), 32'(m_irq(cyc)));
                if ($urandom_range(0, 99) < pct && nfr < 1000) begin
                    b = 8'($urandom);
                    m_push(cyc + 1, b);
                    bus(1'b1, 4'h1, 11'd0, {24'd0, b});
                end else begin
                    step();
                end
            end
            while (cyc < last_e + 2) begin
                chk($sformatf("rnd_tx d%0d t%0d", dv, cyc), 32'(tx), 32'(m_tx(cyc)));
                chk($sformatf("rnd_irq d%0d t%0d", dv, cyc), 32'(irq), 32'(m_irq(cyc)));
                step();
            end
            rd(11'd3, rv);
            chk($sformatf("rnd_txcount d%0d", dv), rv, 32'(nfr));
            rd(11'd1, rv);
            chk($sformatf("rnd_status d%0d", dv), rv, {25'd0, ovf_m, 6'h04});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter RESET_DIV, default 16'd433, reset value of DIVISOR (bit period = DIVISOR+1 clk).
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port en  in  1  I/O-bank select from address decoder; no access effect when 0.
REQ-005 SHALL have port memWrite  in  4  byte-lane write enables; bit0 = wdata[7:0].
REQ-006 SHALL have port addr  in  11  word address; only addr[1:0] decoded, upper bits alias.
REQ-007 SHALL have port wdata  in  32  write data.
REQ-008 SHALL have port rdata  out  32  combinational read data (same-cycle, single-cycle CPU).
REQ-009 SHALL have port tx  out  1  serial line, idle high.
REQ-010 SHALL have port irq  out  1  high while FIFO empty and FSM IDLE.

Function
REQ-011 Register map SHALL be: 0 TXDATA (W), 1 STATUS (R/W1C), 2 DIVISOR (R/W, 16 bits), 3 TXCOUNT (R, any write clears).
REQ-012 rdata SHALL be 0 when en=0 or for TXDATA; unused upper bits read 0.
REQ-013 STATUS read SHALL be {overflow[6], count[5:3] saturating at 7, empty[2], full[1], busy[0]}; busy = state != IDLE.
REQ-014 Write to TXDATA with en=1 and memWrite[0]=1 SHALL push wdata[7:0] at that clock edge; other lanes ignored.
REQ-015 Push SHALL be accepted when count<DEPTH or a pop occurs in the same cycle; otherwise byte dropped and overflow set.
REQ-016 overflow SHALL clear on STATUS write with memWrite[0]=1 and wdata[6]=1; set wins if simultaneous.
REQ-017 DIVISOR write SHALL honour lanes 0 and 1 independently; new value used from next bit boundary.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE: if FIFO non-empty, pop head into shift register, go START; tx=1 in IDLE.
REQ-020 START: tx=0 for one bit period, then DATA.
REQ-021 DATA: 8 bits LSB-first, one bit period each, bit index 0..7, then STOP.
REQ-022 STOP: tx=1 for one bit period; at end pop next byte directly to START if FIFO non-empty (no idle gap), else IDLE.
REQ-023 Bit timer SHALL count 0..DIVISOR inclusive; DIVISOR=0 gives 1 clk/bit.
REQ-024 Latency: push at edge N into empty FIFO with FSM IDLE SHALL drive tx=0 after edge N+1.
REQ-025 TXCOUNT SHALL be 32-bit, increment at each STOP completion, wrap 0xFFFFFFFF->0; clear wins over increment.

Reset
REQ-026 On rst SHALL set tx=1, state IDLE, FIFO empty, overflow=0, TXCOUNT=0, DIVISOR=RESET_DIV, bit timer and index 0.
REQ-027 rst mid-frame SHALL abort the frame, tx=1 after the reset edge, queued bytes discarded.

Configuration
REQ-028 With IO_UART_TX_FIFO_EN defined, DEPTH SHALL be 8 (circular buffer, pointers wrap).
REQ-029 Without IO_UART_TX_FIFO_EN, DEPTH SHALL be 1 (single holding register); register map unchanged, count field max 1.

Structure
REQ-030 Package io_uart_pkg SHALL hold register offsets, FSM state enum, STATUS bit positions, DEPTH.
REQ-031 FIFO SHALL be sub-module io_uart_fifo (push, pop, dout, count, full, empty); FSM, timer and register decode in top.

Verification
REQ-032 Reset, DIVISOR=3, write TXDATA 0xA5 -> tx low after edge N+1, then bits 1,0,1,0,0,1,0,1 each 4 clk, stop high, TXCOUNT=1, irq=1.
REQ-033 FIFO_EN, DIVISOR=0, push 9 bytes back-to-back while IDLE -> 9 accepted (one popped), 10th push sets STATUS bit6; W1C 0x40 clears it.
REQ-034 Without FIFO_EN, push 0x11 then 0x22 in consecutive cycles -> both accepted (pop frees slot), 3rd immediate push sets overflow.
REQ-035 Assert rst during DATA bit 3 -> tx=1 next cycle, STATUS reads 0x04, TXCOUNT=0, DIVISOR=433.
REQ-036 Write DIVISOR 7 mid-bit at DIVISOR=3 -> current bit 4 clk, following bits 8 clk; en=0 writes have no effect, rdata=0.
